// File: rtl/ps2_cmd_pkg.sv
// Shared types for the PS/2 key command stage: command codes, scan codes, FSM states.
// Define PS2_KEY_CMD_UNDO_EN to map Backspace (0x66) to the UNDO command.
package ps2_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NONE     = 3'd0,
    CMD_HOME_P2  = 3'd1,
    CMD_HOME_P3  = 3'd2,
    CMD_GUEST_P2 = 3'd3,
    CMD_GUEST_P3 = 3'd4,
    CMD_PAUSE    = 3'd5,
    CMD_UNDO     = 3'd6
  } cmd_e;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_QUALIFY  = 2'd1,
    ST_HELD     = 2'd2
  } key_state_e;

`ifdef PS2_KEY_CMD_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  // CMD_NONE means "recognised press, but nothing to queue".
  function automatic cmd_e decode_scan(input logic [7:0] sc);
    cmd_e res;
    res = CMD_NONE;
    case (sc)
      SC_A:     res = CMD_HOME_P2;
      SC_S:     res = CMD_HOME_P3;
      SC_K:     res = CMD_GUEST_P2;
      SC_L:     res = CMD_GUEST_P3;
      SC_SPACE: res = CMD_PAUSE;
      SC_BKSP:  res = UNDO_EN ? CMD_UNDO : CMD_NONE;
      default:  res = CMD_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/key_cmd_fifo.sv
// Small command FIFO; a push on a full FIFO is still taken when a pop happens that cycle.
module key_cmd_fifo
  import ps2_cmd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_e push_data,
  input  logic pop,
  output logic full,
  output logic empty,
  output cmd_e head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_acc;
  logic          pop_acc;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == (AW+1)'(DEPTH));
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);
  assign head     = empty ? CMD_NONE : cmd_e'(mem[rd_ptr_reg]);

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_acc) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_cmd.sv
// Resynchronises PS/2 scanner output, qualifies each press and queues one command per press.
// Backspace/UNDO decoding is enabled by defining PS2_KEY_CMD_UNDO_EN.
module ps2_key_cmd
  import ps2_cmd_pkg::*;
#(
  parameter int STABLE_CYC = 4,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_state,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic       overflow
);

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYC - 1);

  logic [8:0] raw_in;
  logic [8:0] sync1_reg;
  logic [8:0] sync2_reg;
  logic [7:0] s_byte;
  logic       s_state;

  key_state_e state_reg;
  logic [7:0] cap_reg;
  logic [7:0] cnt_reg;
  logic       overflow_reg;

  logic       qualified;
  cmd_e       decoded;
  logic       push_req;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  cmd_e       fifo_head;

  assign raw_in = {ps2_state, ps2_byte};

  // Two-flop synchroniser per bit; byte bits are only trusted after stability qualification.
  generate
    for (genvar gi = 0; gi < 9; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
        end else begin
          sync1_reg[gi] <= raw_in[gi];
          sync2_reg[gi] <= sync1_reg[gi];
        end
      end
    end
  endgenerate

  assign s_byte  = sync2_reg[7:0];
  assign s_state = sync2_reg[8];

  assign qualified = (state_reg == ST_QUALIFY) && s_state &&
                     (s_byte == cap_reg) && (cnt_reg == CNT_LAST);
  assign decoded   = decode_scan(cap_reg);
  assign push_req  = qualified && (decoded != CMD_NONE);
  assign pop       = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_RELEASED;
      cap_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_RELEASED: begin
          if (s_state) begin
            state_reg <= ST_QUALIFY;
            cap_reg   <= s_byte;
            cnt_reg   <= '0;
          end
        end
        ST_QUALIFY: begin
          if (!s_state) begin
            state_reg <= ST_RELEASED;
          end else if (s_byte != cap_reg) begin
            cap_reg <= s_byte;
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= ST_HELD;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_HELD: begin
          // Typematic repeats and byte changes are ignored until release.
          if (!s_state) state_reg <= ST_RELEASED;
        end
        default: state_reg <= ST_RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_reg <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow_reg <= 1'b1;
    end
  end

  key_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_req),
    .push_data(decoded),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign cmd_valid = ~fifo_empty;
  assign cmd       = fifo_head;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_ps2_key_cmd.sv
// Directed self-checking bench for ps2_key_cmd (STABLE_CYC=4, DEPTH=4).
module tb_ps2_key_cmd;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_state = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       overflow;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [2:0] log_cmd[$];
  int         log_cyc[$];

  ps2_key_cmd #(
    .STABLE_CYC(4),
    .DEPTH     (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_byte (ps2_byte),
    .ps2_state(ps2_state),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every pop (valid & ready seen mid-cycle means a pop on the next edge).
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      log_cmd.push_back(cmd);
      log_cyc.push_back(cyc);
      $display("pop cmd=%0d cycle=%0d", cmd, cyc);
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_cmd.delete();
    log_cyc.delete();
  endtask

  function automatic logic [2:0] log_at(input int i);
    if (i < log_cmd.size()) return log_cmd[i];
    return 3'bxxx;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < log_cyc.size()) return log_cyc[i];
    return -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    ps2_state = 1'b0;
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(1);
  endtask

  task automatic press(input logic [7:0] b, input int hold, input int rel, output int t0);
    ps2_byte = b;
    wait_cyc(3);
    ps2_state = 1'b1;
    t0 = cyc;
    wait_cyc(hold);
    ps2_state = 1'b0;
    wait_cyc(rel);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cyc(3);
    total_cnt++;
    if (cmd_valid !== 1'b0) $display("FAIL reset_valid: got %0b expected 0", cmd_valid);
    else pass_cnt++;
    total_cnt++;
    if (cmd !== 3'd0) $display("FAIL reset_cmd: got %0d expected 0", cmd);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %0b expected 0", overflow);
    else pass_cnt++;
    reset = 1'b0;
    wait_cyc(2);
  endtask

  task automatic test_single_press();
    int t0;
    cmd_ready = 1'b1;
    clear_log();
    press(8'h1C, 20, 10, t0);
    total_cnt++;
    if (log_cmd.size() !== 1) $display("FAIL single_count: got %0d expected 1", log_cmd.size());
    else pass_cnt++;
    total_cnt++;
    if (log_at(0) !== 3'd1) $display("FAIL single_cmd: got %0d expected 1", log_at(0));
    else pass_cnt++;
    total_cnt++;
    if (cyc_at(0) !== t0 + 7) $display("FAIL single_latency: got %0d expected %0d", cyc_at(0), t0 + 7);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    cmd_ready = 1'b1;
    clear_log();
    ps2_byte = 8'h1B;
    wait_cyc(3);
    ps2_state = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(2);
      ps2_byte = (ps2_byte == 8'h1B) ? 8'h00 : 8'h1B;
    end
    total_cnt++;
    if (log_cmd.size() !== 0) $display("FAIL glitch_nopush: got %0d expected 0", log_cmd.size());
    else pass_cnt++;
    ps2_byte = 8'h1B;
    wait_cyc(12);
    ps2_state = 1'b0;
    wait_cyc(6);
    total_cnt++;
    if (log_cmd.size() !== 1) $display("FAIL glitch_count: got %0d expected 1", log_cmd.size());
    else pass_cnt++;
    total_cnt++;
    if (log_at(0) !== 3'd2) $display("FAIL glitch_cmd: got %0d expected 2", log_at(0));
    else pass_cnt++;
  endtask

  task automatic test_unmapped();
    int t0;
    cmd_ready = 1'b1;
    clear_log();
    ps2_byte = 8'h15;
    wait_cyc(3);
    ps2_state = 1'b1;
    wait_cyc(15);
    // Byte change and typematic resend while held must be ignored.
    ps2_byte = 8'h1C;
    wait_cyc(8);
    ps2_byte = 8'h15;
    wait_cyc(8);
    ps2_state = 1'b0;
    wait_cyc(6);
    total_cnt++;
    if (log_cmd.size() !== 0) $display("FAIL unmapped_nopush: got %0d expected 0", log_cmd.size());
    else pass_cnt++;
    press(8'h4B, 12, 6, t0);
    total_cnt++;
    if (log_cmd.size() !== 1) $display("FAIL unmapped_next_count: got %0d expected 1", log_cmd.size());
    else pass_cnt++;
    total_cnt++;
    if (log_at(0) !== 3'd4) $display("FAIL unmapped_next_cmd: got %0d expected 4", log_at(0));
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int t0;
    logic [7:0] codes [5];
    logic [2:0] exp [4];
    codes = '{8'h1C, 8'h1B, 8'h42, 8'h4B, 8'h29};
    exp = '{3'd1, 3'd2, 3'd3, 3'd4};
    cmd_ready = 1'b0;
    clear_log();
    for (int i = 0; i < 4; i++) press(codes[i], 10, 4, t0);
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_before: got %0b expected 0", overflow);
    else pass_cnt++;
    total_cnt++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd1)
      $display("FAIL ovf_head_hold: got valid=%0b cmd=%0d expected valid=1 cmd=1", cmd_valid, cmd);
    else pass_cnt++;
    press(codes[4], 10, 4, t0);
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_set: got %0b expected 1", overflow);
    else pass_cnt++;
    cmd_ready = 1'b1;
    wait_cyc(8);
    total_cnt++;
    if (log_cmd.size() !== 4) $display("FAIL ovf_drain_count: got %0d expected 4", log_cmd.size());
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (log_at(i) !== exp[i]) $display("FAIL ovf_drain_%0d: got %0d expected %0d", i, log_at(i), exp[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0)
      $display("FAIL ovf_empty: got valid=%0b cmd=%0d expected valid=0 cmd=0", cmd_valid, cmd);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %0b expected 1", overflow);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_qual();
    int t0;
    cmd_ready = 1'b0;
    clear_log();
    press(8'h1C, 10, 4, t0);
    ps2_byte = 8'h42;
    wait_cyc(3);
    ps2_state = 1'b1;
    t0 = cyc;
    wait_cyc(4);
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    total_cnt++;
    if (cmd_valid !== 1'b0) $display("FAIL rstq_valid: got %0b expected 0", cmd_valid);
    else pass_cnt++;
    total_cnt++;
    if (cmd !== 3'd0) $display("FAIL rstq_cmd: got %0d expected 0", cmd);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL rstq_overflow: got %0b expected 0", overflow);
    else pass_cnt++;
    cmd_ready = 1'b1;
    wait_cyc(15);
    ps2_state = 1'b0;
    wait_cyc(5);
    total_cnt++;
    if (log_cmd.size() !== 1) $display("FAIL rstq_count: got %0d expected 1", log_cmd.size());
    else pass_cnt++;
    total_cnt++;
    if (log_at(0) !== 3'd3 || cyc_at(0) !== t0 + 12)
      $display("FAIL rstq_requal: got cmd=%0d cyc=%0d expected cmd=3 cyc=%0d", log_at(0), cyc_at(0), t0 + 12);
    else pass_cnt++;
  endtask

  task automatic test_push_pop_full();
    int t0;
    logic [7:0] codes [4];
    logic [2:0] exp [5];
    codes = '{8'h1C, 8'h1B, 8'h42, 8'h4B};
    exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    do_reset();
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++) press(codes[i], 10, 4, t0);
    clear_log();
    ps2_byte = 8'h29;
    wait_cyc(3);
    ps2_state = 1'b1;
    t0 = cyc;
    wait_cyc(6);
    cmd_ready = 1'b1;
    wait_cyc(1);
    cmd_ready = 1'b0;
    wait_cyc(4);
    ps2_state = 1'b0;
    wait_cyc(3);
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL full_pop_overflow: got %0b expected 0", overflow);
    else pass_cnt++;
    cmd_ready = 1'b1;
    wait_cyc(8);
    total_cnt++;
    if (log_cmd.size() !== 5) $display("FAIL full_pop_count: got %0d expected 5", log_cmd.size());
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (log_at(i) !== exp[i]) $display("FAIL full_pop_%0d: got %0d expected %0d", i, log_at(i), exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_macro();
    int t0;
    cmd_ready = 1'b1;
    clear_log();
    press(8'h66, 12, 6, t0);
`ifdef PS2_KEY_CMD_UNDO_EN
    total_cnt++;
    if (log_cmd.size() !== 1 || log_at(0) !== 3'd6)
      $display("FAIL undo_enabled: got count=%0d cmd=%0d expected count=1 cmd=6", log_cmd.size(), log_at(0));
    else pass_cnt++;
`else
    total_cnt++;
    if (log_cmd.size() !== 0) $display("FAIL undo_disabled: got count=%0d expected 0", log_cmd.size());
    else pass_cnt++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_glitch();
    test_unmapped();
    test_overflow();
    test_reset_mid_qual();
    test_push_pop_full();
    test_macro();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_key_cmd.md
# ps2_key_cmd

Scoreboard command stage directly downstream of the PS/2 scanner. It takes the scanner's `ps2_byte` and `ps2_state`, which are produced in the `ps2k_clk` domain, and resynchronises them into the system clock. It qualifies each key press for byte stability and decodes the scan code into a scoreboard command. Each press yields exactly one command, queued in a small FIFO with a valid/ready handshake to the score controller.

## Interface
- `STABLE_CYC`, default 4: consecutive `clk` cycles the synchronised byte must stay unchanged, with state high, before decode. Range 1–255.
- `DEPTH`, default 4: command FIFO depth. Must be a power of two, 2–16.
- `clk` input 1: system clock. Single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `ps2_byte` input 8: scan code from the scanner. Asynchronous to `clk`.
- `ps2_state` input 1: scanner make flag. 1 = key held, 0 = released or break. Asynchronous to `clk`.
- `cmd_ready` input 1: consumer accepts the head command.
- `cmd_valid` output 1: FIFO not empty.
- `cmd` output 3: head command code.
- `overflow` output 1: sticky flag; a qualified command was dropped because the FIFO was full.

## Operation
- **Synchroniser:** 2-flop synchroniser on each bit of `ps2_byte` and on `ps2_state`, giving `s_byte` and `s_state`.
- **RELEASED state:**
  - `s_state`=1 → go to QUALIFY; `cap`←`s_byte`, `cnt`←0.
- **QUALIFY state:**
  - `s_state`=0 → RELEASED.
  - `s_byte`≠`cap` → `cap`←`s_byte`, `cnt`←0.
  - Otherwise `cnt`++.
  - When `cnt`==`STABLE_CYC`−1 with byte still equal: decode `cap`, attempt a push, go to HELD.
- **HELD state:**
  - `s_state`=0 → RELEASED.
  - Typematic repeats and byte changes while held are ignored.
- **Decode table** (command codes):
  - 0x1C (A) → 1, HOME_P2
  - 0x1B (S) → 2, HOME_P3
  - 0x42 (K) → 3, GUEST_P2
  - 0x4B (L) → 4, GUEST_P3
  - 0x29 (Space) → 5, PAUSE
  - Any other byte → no push; FSM still goes to HELD.
- **FIFO behaviour:**
  - Push is accepted if not full, or if full and a pop occurs in the same cycle.
  - Otherwise the command is dropped and `overflow`←1. Only `reset` clears `overflow`.
  - Pop occurs when `cmd_valid`&`cmd_ready`.
  - Pointers wrap modulo `DEPTH`; occupancy counter width is clog2(`DEPTH`)+1.
  - `cmd` holds its head value while `cmd_valid`=1 and `cmd_ready`=0.
  - When empty, `cmd` = 0.
- **Reset:**
  - FSM → RELEASED; `cnt`, `cap` and synchronisers cleared.
  - FIFO emptied.
  - Outputs: `cmd_valid`=0, `cmd`=0, `overflow`=0.
  - Reset mid-qualification abandons the pending press. A key still held after reset is issued once it qualifies again.

## Timing
- `ps2_state` rising between edges 0 and 1, with a stable byte: QUALIFY entered at edge 3; push at edge 3+`STABLE_CYC`; `cmd_valid` high after that edge. Default latency is 7 cycles.
- Pop on edge N gives the new head (or `cmd_valid`=0) after edge N.
- Push into an empty FIFO with `cmd_ready`=1: the command is visible for exactly one cycle.
- Minimum release time for a second press: `s_state` must be seen low for ≥1 cycle in HELD.

## Configuration
- **`PS2_KEY_CMD_UNDO_EN` defined:** 0x66 (Backspace) decodes to command 6, UNDO, and is queued like any other command.
- **Not defined:** 0x66 is treated as an unmapped code. Command 6 is never produced.

## Structure
- **Package `ps2_cmd_pkg`:**
  - Command enum: CMD_NONE=0 … CMD_UNDO=6, width 3.
  - Scan-code constants: SC_A, SC_S, SC_K, SC_L, SC_SPACE, SC_BKSP.
  - FSM state enum.
- **Sub-module `key_cmd_fifo`:**
  - Parameterised by `DEPTH`.
  - Push/pop ports, full/empty, head data.
  - Overflow logic stays in the top level.

## Test plan
- **Single press:** byte 0x1C held with state high for 20 cycles, then released, `cmd_ready`=1 → exactly one `cmd`=1, valid 7 cycles after the state rise, then nothing.
- **Glitch:** byte toggles 0x1B↔0x00 every 2 cycles with state high, `STABLE_CYC`=4 → no push. Byte then settles at 0x1B → one `cmd`=2.
- **Unmapped key:** 0x15 pressed → no push. Repeats while held produce nothing. Pressing 0x4B after release → `cmd`=4.
- **Overflow:** `cmd_ready`=0, presses 0x1C, 0x1B, 0x42, 0x4B, 0x29 → FIFO holds 1, 2, 3, 4 and `overflow`=1. Raising `cmd_ready` drains 1, 2, 3, 4 in order. A push on a full FIFO in the same cycle as a pop is accepted.
- **Reset mid-qualification:** `reset` asserted in QUALIFY → all outputs 0, FIFO empty, and no command from that press until it qualifies again.
- **Macro:** 0x66 press → `cmd`=6 with `PS2_KEY_CMD_UNDO_EN` defined; no push without it.
